// File: rtl/eb_pkg.sv
// Shared helpers for the elastic-buffer credit link.
package eb_pkg;

  // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
  function automatic int eb_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Counter width able to hold 0..credits inclusive.
  function automatic int eb_credit_width(input int credits);
    return eb_clog2(credits + 1);
  endfunction

endpackage

// File: rtl/eb_credit_cnt.sv
// Up/down credit counter: starts full, saturates at INIT, flags a sticky overflow.
module eb_credit_cnt
  import eb_pkg::*;
#(
  parameter int INIT = 4,
  localparam int CW = eb_credit_width(INIT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero,
  output logic          full,
  output logic          ovf
);

  localparam logic [CW-1:0] INIT_VAL = CW'(INIT);

  assign zero = (cnt == '0);
  assign full = (cnt == INIT_VAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= INIT_VAL;
      ovf <= 1'b0;
    end else begin
      if (inc && !dec) begin
        // A return while already full means the remote side lost track; hold and flag.
        if (full) ovf <= 1'b1;
        else      cnt <= cnt + 1'b1;
      end else if (dec && !inc && !zero) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/eb_credit_tx.sv
// Credit-flow-controlled transmitter: req/ack upstream, valid-only registered downstream.
module eb_credit_tx
  import eb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CREDITS = 4,
  localparam int CW = eb_credit_width(CREDITS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t_req,
  output logic             t_ack,
  input  logic [WIDTH-1:0] t_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             cr_ret,
  output logic [CW-1:0]    credit_cnt,
  output logic             idle,
  output logic             err_ovf
);

  logic acc;
  logic cnt_zero;
  logic cnt_full;

  eb_credit_cnt #(
    .INIT (CREDITS)
  ) u_credit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cr_ret),
    .dec     (acc),
    .cnt     (credit_cnt),
    .zero    (cnt_zero),
    .full    (cnt_full),
    .ovf     (err_ovf)
  );

  // Ack comes only from the registered count, so a same-cycle return cannot raise it.
  assign t_ack = !cnt_zero;
  assign acc   = t_req && t_ack;
  assign idle  = cnt_full && !o_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= acc;
      if (acc) o_data <= t_data;
    end
  end

endmodule

// File: tb/tb_eb_credit_tx.sv
// Directed and random checks for eb_credit_tx with CREDITS=4, WIDTH=32.
module tb_eb_credit_tx;

  localparam int WIDTH = 32;
  localparam int CREDITS = 4;
  localparam int CW = 3;

  logic             clk;
  logic             reset_n;
  logic             t_req;
  logic             t_ack;
  logic [WIDTH-1:0] t_data;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             cr_ret;
  logic [CW-1:0]    credit_cnt;
  logic             idle;
  logic             err_ovf;

  int total = 0;
  int bad = 0;

  eb_credit_tx #(
    .WIDTH   (WIDTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .t_req      (t_req),
    .t_ack      (t_ack),
    .t_data     (t_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .cr_ret     (cr_ret),
    .credit_cnt (credit_cnt),
    .idle       (idle),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] rem_q[$];
  int max_occ;
  int accepts;

  initial begin
    reset_n = 1'b0;
    t_req   = 1'b0;
    t_data  = '0;
    cr_ret  = 1'b0;
    #12;
    check("rst_credit", credit_cnt, 4);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_err", err_ovf, 0);
    check("rst_idle", idle, 1);
    check("rst_ack", t_ack, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // 1: drain all credits with continuous requests
    for (int i = 0; i < 6; i++) begin
      t_req  = 1'b1;
      t_data = 32'(i + 1);
      check("t1_ack", t_ack, (i < 4) ? 1 : 0);
      check("t1_credit", credit_cnt, (i < 4) ? 4 - i : 0);
      step();
      check("t1_valid", o_valid, (i < 4) ? 1 : 0);
      if (i < 4) check("t1_data", o_data, i + 1);
    end
    check("t1_idle", idle, 0);

    // 2: a return at zero credits only opens ack next cycle
    cr_ret = 1'b1;
    check("t2_ack_same", t_ack, 0);
    step();
    cr_ret = 1'b0;
    t_data = 32'd100;
    check("t2_credit1", credit_cnt, 1);
    check("t2_ack_next", t_ack, 1);
    check("t2_valid0", o_valid, 0);
    step();
    check("t2_valid1", o_valid, 1);
    check("t2_data", o_data, 100);
    check("t2_credit0", credit_cnt, 0);
    check("t2_ack_low", t_ack, 0);
    step();
    check("t2_valid_end", o_valid, 0);

    // 3: simultaneous accept and return hold the count
    t_req  = 1'b0;
    cr_ret = 1'b1;
    step();
    step();
    cr_ret = 1'b0;
    check("t3_credit_start", credit_cnt, 2);
    t_req  = 1'b1;
    cr_ret = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t_data = 32'(200 + i);
      check("t3_credit", credit_cnt, 2);
      check("t3_ack", t_ack, 1);
      step();
      check("t3_valid", o_valid, 1);
      check("t3_data", o_data, 200 + i);
    end
    t_req  = 1'b0;
    cr_ret = 1'b0;
    step();
    check("t3_credit_end", credit_cnt, 2);

    // 4: return while full sets the sticky error
    cr_ret = 1'b1;
    step();
    step();
    cr_ret = 1'b0;
    check("t4_credit_full", credit_cnt, 4);
    check("t4_idle_before", idle, 1);
    check("t4_err_before", err_ovf, 0);
    cr_ret = 1'b1;
    step();
    cr_ret = 1'b0;
    check("t4_err_set", err_ovf, 1);
    check("t4_credit_sat", credit_cnt, 4);
    check("t4_idle", idle, 1);
    step();
    step();
    check("t4_err_sticky", err_ovf, 1);

    // 5: async reset mid-stream
    t_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_data = 32'(300 + i);
      step();
    end
    check("t5_credit_pre", credit_cnt, 1);
    check("t5_valid_pre", o_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_credit_rst", credit_cnt, 4);
    check("t5_valid_rst", o_valid, 0);
    check("t5_err_rst", err_ovf, 0);
    t_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    t_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      t_data = 32'(400 + i);
      check("t5_ack", t_ack, (i < 4) ? 1 : 0);
      step();
      check("t5_valid", o_valid, (i < 4) ? 1 : 0);
    end
    t_req = 1'b0;

    // 6: random traffic against a depth-4 remote FIFO model
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    max_occ = 0;
    accepts = 0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      if (o_valid) begin
        if (exp_q.size() == 0) check("t6_extra_beat", 1, 0);
        else check("t6_data", o_data, exp_q.pop_front());
        rem_q.push_back(o_data);
        if (rem_q.size() > max_occ) max_occ = rem_q.size();
      end
      cr_ret = 1'b0;
      if (rem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        void'(rem_q.pop_front());
        cr_ret = 1'b1;
      end
      t_req  = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      t_data = $urandom;
      if (t_req && t_ack) begin
        exp_q.push_back(t_data);
        accepts++;
      end
      step();
    end
    cr_ret = 1'b0;
    check("t6_remote_ovf", (max_occ > 4) ? 1 : 0, 0);
    check("t6_pending", exp_q.size(), 0);
    check("t6_err", err_ovf, 0);
    check("t6_credit_home", credit_cnt, 4);
    check("t6_idle", idle, 1);
    check("t6_some_traffic", (accepts > 1000) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eb_credit_tx.md
Name: eb_credit_tx

Overview:
- Transmitter end of a credit-flow-controlled elastic link feeding a remote receive FIFO.
- Upstream side is the team's standard req/ack target interface (t_req/t_ack).
- Downstream side is valid-only: no ready or ack. The remote FIFO signals each freed entry with a one-cycle credit-return pulse.
- Keeps the remote FIFO from overflowing by never launching a beat without a held credit; registers the outgoing data.

Parameters:
- WIDTH, 32, payload width in bits.
- CREDITS, 4, remote FIFO depth = initial credit count; legal range 1..255.
- CW, $clog2(CREDITS+1), credit counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- t_req  input  1  upstream request; payload valid on t_data.
- t_ack  output  1  upstream acknowledge; a beat transfers when t_req && t_ack.
- t_data  input  WIDTH  upstream payload.
- o_valid  output  1  downstream beat valid; one beat per cycle high.
- o_data  output  WIDTH  downstream payload, registered.
- cr_ret  input  1  credit return pulse; one pulse per remote entry freed.
- credit_cnt  output  CW  credits currently held.
- idle  output  1  all credits home and no beat launching.
- err_ovf  output  1  sticky error: credit returned while already holding CREDITS.

Behaviour:
- Reset values (async on reset_n low):
  - credit_cnt = CREDITS
  - o_valid = 0, o_data = 0
  - err_ovf = 0
- t_ack is combinational: t_ack = (credit_cnt != 0). It does not depend on t_req, so there is no comb loop.
- Accept: acc = t_req && t_ack.
  - Next cycle: o_valid = 1, o_data = t_data (sampled).
  - Latency is exactly 1 cycle, t_req to o_valid.
- No accept: o_valid = 0 next cycle; o_data holds its last value (don't-care while o_valid = 0).
- Throughput: 1 beat/cycle while credits remain. Back-to-back accepts produce a continuous o_valid stream.
- Credit counter update:
  - acc && !cr_ret: credit_cnt - 1.
  - !acc && cr_ret: credit_cnt + 1.
  - acc && cr_ret: unchanged.
  - neither: unchanged.
- Boundary, zero credits:
  - t_ack = 0; a cr_ret in this cycle does not raise t_ack until the next cycle (registered count).
  - credit_cnt never goes below 0, because acc is impossible at 0.
- Boundary, full credits:
  - cr_ret with credit_cnt == CREDITS and !acc: count saturates at CREDITS and err_ovf is set (sticky until reset).
  - cr_ret with acc in the same cycle at CREDITS is legal: count unchanged, no error.
- idle = (credit_cnt == CREDITS) && !o_valid, combinational from registers.
- Reset mid-operation:
  - In-flight beats and outstanding credits are discarded; the count returns to CREDITS.
  - The system must reset the remote FIFO on the same reset_n. No partial-reset recovery is supported.
- Arithmetic: all counter ops are CW bits wide, unsigned; no wrap is reachable except the overflow case, which saturates.

Decomposition:
- Shared package eb_pkg: function eb_clog2, the credit-width derivation, and the localparam convention CW = eb_clog2(CREDITS+1).
- One sub-module, eb_credit_cnt: an up/down counter with init value CREDITS, inc/dec inputs, zero flag, full flag and sticky overflow flag.
- eb_credit_tx instantiates eb_credit_cnt and holds the o_valid/o_data register stage.

Test Plan (CREDITS = 4, WIDTH = 32):
1. Reset, then t_req held for 6 cycles, no cr_ret, t_data = 1,2,3,...
   -> t_ack high for 4 cycles, then low.
   -> o_valid high for 4 cycles, one cycle after each accept; o_data = 1,2,3,4.
   -> credit_cnt steps 4,3,2,1,0.
2. From credit_cnt = 0 with t_req held, pulse cr_ret once.
   -> t_ack high in the following cycle only; one beat launched; credit_cnt returns to 0.
3. credit_cnt = 2; t_req and cr_ret both held high for 10 cycles.
   -> credit_cnt stays 2 throughout; 10 consecutive o_valid beats with data in order.
4. Idle link with credit_cnt = 4; pulse cr_ret.
   -> err_ovf = 1 next cycle and stays 1; credit_cnt stays 4; idle stays 1.
5. Mid-stream, with credit_cnt = 1 and o_valid = 1, assert reset_n low asynchronously between clock edges.
   -> credit_cnt = 4, o_valid = 0, err_ovf = 0 immediately.
   -> After release, 4 beats are accepted again.
6. Random t_req / cr_ret traffic, 10k cycles, against a model remote FIFO of depth 4.
   -> no remote overflow; output data sequence equals input sequence; err_ovf stays 0.
